// File: rtl/crc_ccitt_pkg.sv
// crc_ccitt_pkg: CRC-CCITT constants, checker state encoding and the shared single-bit LFSR step
package crc_ccitt_pkg;
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_GOOD_RESIDUE = 16'h0000;
  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;
  function automatic logic [15:0] crc_step(input logic [15:0] lfsr, input logic b);
    return {lfsr[14:0], 1'b0} ^ ({16{b ^ lfsr[15]}} & CRC_POLY);
  endfunction
endpackage

// File: rtl/serial_crc_checker_if.sv
// serial_crc_checker_if: bit-serial frame input and frame verdict outputs of the CRC checker
//  master: deframer side, drives bit_valid/bit_in/sof/eof, observes verdicts
//  slave : checker side, consumes bits, drives done/crc_ok/crc_err/len_err/bit_count/rx_fcs/residue
interface serial_crc_checker_if #(parameter int MAX_BITS = 4112);
  localparam int CNT_W = $clog2(MAX_BITS + 2);
  logic             bit_valid;
  logic             bit_in;
  logic             sof;
  logic             eof;
  logic             done;
  logic             crc_ok;
  logic             crc_err;
  logic             len_err;
  logic [CNT_W-1:0] bit_count;
  logic [15:0]      rx_fcs;
  logic [15:0]      residue;
  modport master (output bit_valid, bit_in, sof, eof,
                  input done, crc_ok, crc_err, len_err, bit_count, rx_fcs, residue);
  modport slave (input bit_valid, bit_in, sof, eof,
                 output done, crc_ok, crc_err, len_err, bit_count, rx_fcs, residue);
endinterface

// File: rtl/crc_ccitt_lfsr.sv
// crc_ccitt_lfsr: CRC-CCITT LFSR stepping one bit per enabled cycle, restartable from the init value
//  clk, reset : clock, synchronous active-high reset (state -> CRC_INIT)
//  i_start    : with i_en, step i_bit from CRC_INIT instead of the held state
//  i_en       : accept i_bit this cycle
//  i_bit      : serial bit
//  o_next     : LFSR state after stepping this cycle's bit
module crc_ccitt_lfsr
  import crc_ccitt_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic        i_en,
  input  logic        i_bit,
  output logic [15:0] o_next
);
  logic [15:0] r_lfsr;
  assign o_next = crc_step(i_start ? CRC_INIT : r_lfsr, i_bit);
  always_ff @(posedge clk)
    if (reset) r_lfsr <= CRC_INIT;
    else if (i_en) r_lfsr <= o_next;
endmodule

// File: rtl/serial_crc_checker.sv
// serial_crc_checker: receive-side CRC-CCITT frame checker for MSB-first bit-serial frames
//  clk, reset : clock, synchronous active-high reset
//  bus        : slave side of serial_crc_checker_if (bits in, frame verdict out)
module serial_crc_checker
  import crc_ccitt_pkg::*;
#(
  parameter int MIN_BITS = 24,
  parameter int MAX_BITS = 4112,
  localparam int CNT_W = $clog2(MAX_BITS + 2)
) (
  input logic                 clk,
  input logic                 reset,
  serial_crc_checker_if.slave bus
);
  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_BITS);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_BITS);
  localparam logic [CNT_W-1:0] SAT_C = CNT_W'(MAX_BITS + 1);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt, r_bit_count;
  logic [15:0]      r_rx_sr, r_rx_fcs, r_residue;
  logic             r_done, r_crc_ok, r_crc_err, r_len_err;
  logic             w_start, w_take, w_end, w_len_err, w_crc_err;
  logic [CNT_W-1:0] w_cnt;
  logic [15:0]      w_sr, w_lfsr;
  // a valid sof always opens a frame, even mid-frame (the old frame is dropped silently)
  assign w_start = bus.bit_valid & bus.sof;
  assign w_take = w_start | (bus.bit_valid & (r_state == RECV));
  assign w_end = w_take & bus.eof;
  assign w_cnt = w_start ? ONE_C : (r_cnt == SAT_C ? r_cnt : r_cnt + ONE_C);
  assign w_sr = {w_start ? 15'd0 : r_rx_sr[14:0], bus.bit_in};
  assign w_len_err = (w_cnt < MIN_C) || (w_cnt > MAX_C);
  assign w_crc_err = w_lfsr != CRC_GOOD_RESIDUE;
  crc_ccitt_lfsr u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .i_start(w_start),
    .i_en   (w_take),
    .i_bit  (bus.bit_in),
    .o_next (w_lfsr)
  );
  // verdicts are captured from the post-eof-bit values so they are valid with done
  always_ff @(posedge clk)
    if (reset) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_rx_sr <= '0;
      r_done <= 1'b0;
      r_crc_ok <= 1'b0;
      r_crc_err <= 1'b0;
      r_len_err <= 1'b0;
      r_bit_count <= '0;
      r_rx_fcs <= 16'h0000;
      r_residue <= CRC_INIT;
    end else begin
      r_done <= w_end;
      if (w_take) begin
        r_cnt <= w_cnt;
        r_rx_sr <= w_sr;
      end
      if (w_end) begin
        r_state <= DONE;
        r_bit_count <= w_cnt;
        r_rx_fcs <= w_sr;
        r_residue <= w_lfsr;
        r_len_err <= w_len_err;
        r_crc_err <= w_crc_err;
        r_crc_ok <= !w_len_err && !w_crc_err;
      end else if (w_take) r_state <= RECV;
      else if (r_state == DONE) r_state <= IDLE;
    end
  assign bus.done = r_done;
  assign bus.crc_ok = r_crc_ok;
  assign bus.crc_err = r_crc_err;
  assign bus.len_err = r_len_err;
  assign bus.bit_count = r_bit_count;
  assign bus.rx_fcs = r_rx_fcs;
  assign bus.residue = r_residue;
endmodule

// File: tb/tb_serial_crc_checker.sv
// tb_serial_crc_checker: randomized frame-level scoreboard bench for serial_crc_checker
module tb_serial_crc_checker;
  localparam int MIN_BITS = 24;
  localparam int MAX_BITS = 4112;
  typedef bit bq_t[$];
  typedef byte unsigned bytes_t[$];
  typedef struct packed {
    logic        ok, cerr, lerr;
    logic [12:0] cnt;
    logic [15:0] fcs, res;
  } verdict_t;
  typedef struct {
    int       due;
    verdict_t v;
  } exp_t;
  localparam verdict_t RST_V = verdict_t'({3'b000, 13'd0, 16'h0000, 16'hFFFF});
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int checks = 0, errors = 0, n_done = 0, n_exp = 0;
  bit armed = 1'b0;
  verdict_t last, obs;
  exp_t expq[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  serial_crc_checker_if bus ();
  serial_crc_checker dut (.clk(clk), .reset(reset), .bus(bus));
  assign obs = {bus.crc_ok, bus.crc_err, bus.len_err, bus.bit_count, bus.rx_fcs, bus.residue};
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  // frame-level expectation: residue is the remainder of the whole frame under 0x1021 from 0xFFFF
  function automatic verdict_t model(input bq_t q);
    verdict_t v;
    logic [15:0] c = 16'hFFFF;
    int n = q.size();
    foreach (q[i]) c = {c[14:0], 1'b0} ^ ((q[i] ^ c[15]) ? 16'h1021 : 16'h0000);
    v.fcs = 16'h0000;
    for (int i = (n > 16 ? n - 16 : 0); i < n; i++) v.fcs = {v.fcs[14:0], q[i]};
    v.cnt = 13'(n > MAX_BITS ? MAX_BITS + 1 : n);
    v.lerr = (n < MIN_BITS) || (n > MAX_BITS);
    v.res = c;
    v.cerr = c != 16'h0000;
    v.ok = !v.lerr && !v.cerr;
    return v;
  endfunction
  // transmitter-side FCS computed bytewise, appended MSB first
  function automatic bq_t make_frame(input bytes_t d);
    bq_t q;
    logic [15:0] c = 16'hFFFF;
    byte unsigned b;
    foreach (d[i]) begin
      b = d[i];
      c = c ^ {b, 8'h00};
      for (int k = 0; k < 8; k++) c = c[15] ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
      for (int k = 7; k >= 0; k--) q.push_back(b[k]);
    end
    for (int k = 15; k >= 0; k--) q.push_back(c[k]);
    return q;
  endfunction
  function automatic bq_t rand_bits(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(1'($urandom));
    return q;
  endfunction
  function automatic bq_t rand_frame(input int nbytes);
    bytes_t d;
    for (int i = 0; i < nbytes; i++) d.push_back(8'($urandom));
    return make_frame(d);
  endfunction
  task automatic drive(input logic v, input logic b, input logic s, input logic e);
    @(negedge clk);
    bus.bit_valid = v;
    bus.bit_in = b;
    bus.sof = s;
    bus.eof = e;
  endtask
  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
  endtask
  task automatic noise(input int n);
    repeat (n) drive(1'($urandom), 1'($urandom), 1'b0, 1'($urandom));
  endtask
  task automatic send(input bq_t q, input int gap, input bit term);
    exp_t e;
    for (int i = 0; i < q.size(); i++) begin
      while (int'($urandom_range(99)) < gap) drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
      drive(1'b1, q[i], i == 0, term && (i == q.size() - 1));
    end
    if (term) begin
      e.due = cyc + 1;
      e.v = model(q);
      expq.push_back(e);
      n_exp++;
    end
  endtask
  always @(negedge clk)
    if (!armed || reset) last = RST_V;
    else if (bus.done) begin
      exp_t e;
      n_done++;
      if (expq.size() == 0) chk("spurious_done", 1, 0);
      else begin
        e = expq.pop_front();
        chk("done_latency", 64'(cyc), 64'(e.due));
        chk("crc_ok", obs.ok, e.v.ok);
        chk("crc_err", obs.cerr, e.v.cerr);
        chk("len_err", obs.lerr, e.v.lerr);
        chk("bit_count", obs.cnt, e.v.cnt);
        chk("rx_fcs", obs.fcs, e.v.fcs);
        chk("residue", obs.res, e.v.res);
        last = e.v;
      end
    end else chk("status_stable", obs, last);
  initial begin
    string s;
    bytes_t d;
    bq_t q0, q1, q;
    int base, idx;
    bus.bit_valid = 1'b0;
    bus.bit_in = 1'b0;
    bus.sof = 1'b0;
    bus.eof = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_done", bus.done, 0);
    chk("rst_crc_ok", bus.crc_ok, 0);
    chk("rst_crc_err", bus.crc_err, 0);
    chk("rst_len_err", bus.len_err, 0);
    chk("rst_bit_count", bus.bit_count, 0);
    chk("rst_rx_fcs", bus.rx_fcs, 16'h0000);
    chk("rst_residue", bus.residue, 16'hFFFF);
    reset = 1'b0;
    armed = 1'b1;
    s = "123456789";
    for (int i = 0; i < s.len(); i++) d.push_back(s[i]);
    q0 = make_frame(d);
    send(q0, 0, 1'b1);
    idle(2);
    chk("std_crc_ok", bus.crc_ok, 1);
    chk("std_crc_err", bus.crc_err, 0);
    chk("std_rx_fcs", bus.rx_fcs, 16'h29B1);
    chk("std_bit_count", bus.bit_count, 88);
    chk("std_residue", bus.residue, 16'h0000);
    q1 = q0;
    q1[10] = ~q1[10];
    send(q1, 10, 1'b1);
    idle(2);
    chk("flip_crc_err", bus.crc_err, 1);
    chk("flip_crc_ok", bus.crc_ok, 0);
    chk("flip_len_err", bus.len_err, 0);
    chk("flip_residue_nz", bus.residue != 16'h0000, 1);
    q.delete();
    for (int i = 0; i < 16; i++) q.push_back(1'b1);
    send(q, 0, 1'b1);
    idle(2);
    chk("short_len_err", bus.len_err, 1);
    chk("short_crc_ok", bus.crc_ok, 0);
    chk("short_residue", bus.residue, 16'h0000);
    base = n_done;
    send(rand_bits(40), 0, 1'b0);
    send(q0, 0, 1'b1);
    idle(2);
    chk("resync_one_done", n_done - base, 1);
    chk("resync_crc_ok", bus.crc_ok, 1);
    base = n_done;
    send(q0, 0, 1'b1);
    send(q0, 0, 1'b1);
    q.delete();
    q.push_back(1'b1);
    send(q, 0, 1'b1);
    idle(2);
    chk("b2b_three_done", n_done - base, 3);
    chk("single_len_err", bus.len_err, 1);
    chk("single_bit_count", bus.bit_count, 1);
    send(rand_bits(30), 0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    bus.bit_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    base = n_done;
    send(q0, 40, 1'b1);
    idle(2);
    chk("post_reset_one_done", n_done - base, 1);
    chk("post_reset_crc_ok", bus.crc_ok, 1);
    send(rand_frame(1), 5, 1'b1);
    noise(2);
    send(rand_bits(23), 5, 1'b1);
    noise(2);
    send(rand_frame(512), 0, 1'b1);
    noise(2);
    send(rand_frame(513), 0, 1'b1);
    noise(2);
    for (int f = 0; f < 30; f++) begin
      q = rand_frame(int'($urandom_range(0, 12)));
      if ($urandom_range(3) == 0) begin
        idx = int'($urandom_range(0, q.size() - 1));
        q[idx] = ~q[idx];
      end
      if ($urandom_range(4) == 0) q.push_back(1'($urandom));
      send(q, int'($urandom_range(0, 30)), 1'b1);
      if ($urandom_range(1) == 1) noise(int'($urandom_range(1, 4)));
    end
    idle(4);
    chk("queue_drained", 64'(expq.size()), 0);
    chk("done_total", 64'(n_done), 64'(n_exp));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
